// File: rtl/vga_line_fetch.sv
// vga_line_fetch: prefetches the next scan line from a word-wide framebuffer
// into a ping-pong pair of line buffers and drives a registered pixel colour
// that lines up with the registered VGA syncs from the timing controller.
//
// Ports:
//   clk, reset_          pixel clock, asynchronous active-low reset
//   need, hNeed, vNeed   pixel request from the timing controller
//   mem_req, mem_addr    word read request; held stable until mem_ack
//   mem_ack, mem_data    read accepted, data valid in the same cycle
//   rgb                  registered pixel colour (0 outside visible area)
//   underrun             sticky: a line started before its fetch finished
module vga_line_fetch #(
  parameter int HC       = 800,
  parameter int VC       = 600,
  parameter int PIX_W    = 8,
  parameter int WORD_PIX = 4,
  parameter int ADDR_W   = 20,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                      clk,
  input  logic                      reset_,
  input  logic                      need,
  input  logic [9:0]                hNeed,
  input  logic [9:0]                vNeed,
  output logic                      mem_req,
  output logic [ADDR_W-1:0]         mem_addr,
  input  logic                      mem_ack,
  input  logic [PIX_W*WORD_PIX-1:0] mem_data,
  output logic [PIX_W-1:0]          rgb,
  output logic                      underrun
);

  localparam int WPL = HC / WORD_PIX;                 // words per line
  localparam int WW  = (WPL > 1) ? $clog2(WPL) : 1;
  localparam int IW  = (HC > 1) ? $clog2(HC) : 1;

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t          state, state_nx;
  logic [WW-1:0]   word, word_nx;
  logic            start_pending, sp_nx;
  logic            ur_nx;
  logic            wr_en;
  logic            need_d;
  logic            line_start;
  logic            front;
  logic [9:0]      fetch_line;
  logic            rd_sel;
  logic [IW-1:0]   wbase;

  logic [PIX_W-1:0] lbuf [2][HC];

  assign line_start = need & ~need_d;
  assign mem_addr   = BASE_ADDR + ADDR_W'(fetch_line) * ADDR_W'(WPL) + ADDR_W'(word);
  assign wbase      = IW'(word) * IW'(WORD_PIX);
  // On a line start the swap has not landed yet, so read the buffer that is
  // about to become front.
  assign rd_sel     = line_start ? ~front : front;

  always_comb begin
    state_nx = state;
    word_nx  = word;
    sp_nx    = start_pending;
    ur_nx    = underrun;
    wr_en    = 1'b0;
    mem_req  = (state == REQ);
    case (state)
      IDLE: if (start_pending && !line_start) begin
        sp_nx    = 1'b0;
        word_nx  = '0;
        state_nx = REQ;
      end
      REQ: begin
        if (line_start) begin
          // Fetch did not finish in time: abandon it, an ack here is dropped,
          // and the IDLE pass gives the one-cycle request gap before restart.
          ur_nx    = 1'b1;
          state_nx = IDLE;
        end else if (mem_ack) begin
          wr_en = 1'b1;
          if (word == WW'(WPL - 1)) state_nx = DONE;
          else                      word_nx  = word + 1'b1;
        end
      end
      DONE: if (line_start) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (line_start) sp_nx = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state         <= IDLE;
      word          <= '0;
      start_pending <= 1'b1;
      underrun      <= 1'b0;
      need_d        <= 1'b0;
      front         <= 1'b0;
      fetch_line    <= '0;
    end else begin
      state         <= state_nx;
      word          <= word_nx;
      start_pending <= sp_nx;
      underrun      <= ur_nx;
      need_d        <= need;
      if (line_start) begin
        front      <= ~front;
        fetch_line <= (vNeed == 10'(VC - 1)) ? 10'd0 : vNeed + 10'd1;
      end
    end
  end

  // Line buffers carry no reset; only the back buffer is ever written.
  always_ff @(posedge clk) begin
    if (wr_en)
      for (int k = 0; k < WORD_PIX; k++)
        lbuf[~front][wbase + IW'(k)] <= mem_data[k*PIX_W +: PIX_W];
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_)
      rgb <= '0;
    else
      rgb <= (need && int'(hNeed) < HC) ? lbuf[rd_sel][IW'(hNeed)] : '0;
  end

endmodule

// File: doc/vga_line_fetch.md
Name: vga_line_fetch

Overview:
Downstream consumer of the VGA timing controller's need/hNeed/vNeed outputs. Prefetches one scan line ahead from a word-wide framebuffer memory into a ping-pong pair of line buffers. Drives a registered pixel colour aligned with the registered VGA_HS/VGA_VS. Reports a sticky underrun flag when a line is not fully fetched in time.

Parameters:
HC, 800, visible pixels per line; must be a multiple of WORD_PIX
VC, 600, visible lines per frame
PIX_W, 8, bits per pixel (RGB 3-3-2)
WORD_PIX, 4, pixels per memory word; memory word width = PIX_W*WORD_PIX
ADDR_W, 20, memory word-address width
BASE_ADDR, 0, word address of pixel (0,0)

Ports:
clk  in  1  pixel clock, same clock as the timing controller
reset_  in  1  asynchronous, active-low reset
need  in  1  pixel hNeed of line vNeed is required this cycle
hNeed  in  10  pixel column, 0..HC-1
vNeed  in  10  visible line index, 0..VC-1
mem_req  out  1  memory read request
mem_addr  out  ADDR_W  word address, stable while mem_req high
mem_ack  in  1  read accepted; mem_data valid in the same cycle
mem_data  in  PIX_W*WORD_PIX  read data; pixel k in bits [k*PIX_W +: PIX_W], k=0 is leftmost
rgb  out  PIX_W  pixel colour, registered
underrun  out  1  sticky; set when a line start finds its fetch incomplete

Behaviour:
- Reset, asynchronous on reset_ low: rgb=0, mem_req=0, mem_addr=BASE_ADDR, underrun=0, front=buffer 0, FSM=IDLE, fetch_line=0, start_pending=1. Buffer contents are undefined.
- Line start: line_start = need & ~need_d, where need_d is need registered.
- On line_start:
  - Swap: front <= back. The read in that same cycle already uses the new front buffer.
  - Fetch target for the next line: fetch_line <= (vNeed==VC-1) ? 0 : vNeed+1.
  - Set start_pending.
- Fetch FSM states: IDLE, REQ, DONE.
  - IDLE with start_pending: clear start_pending, word=0, go to REQ.
  - REQ: mem_req=1, mem_addr = BASE_ADDR + fetch_line*(HC/WORD_PIX) + word. Arithmetic is done at ADDR_W width and wraps modulo 2^ADDR_W.
  - REQ with mem_ack at posedge: write mem_data into back buffer slots word*WORD_PIX .. +WORD_PIX-1.
    - If word==HC/WORD_PIX-1, go to DONE.
    - Otherwise word+1, stay in REQ. The next request may be issued the following cycle, so back-to-back acks give 1 word/clk.
  - DONE: mem_req=0. Wait for line_start; at line_start go to IDLE.
- Underrun: line_start while FSM is in REQ.
  - underrun <= 1 (cleared only by reset).
  - mem_req drops for exactly one cycle; an ack in that cycle is ignored.
  - The fetch restarts at word 0 of the new fetch_line.
  - The swap still happens, so stale or partial data is displayed.
- First frame after reset: start_pending=1 fetches line 0 into back. The first line_start swaps it to front.
- Pixel output, 1-cycle latency: rgb <= need ? readbuf[hNeed] : 0, where readbuf = line_start ? back : front.
- hNeed >= HC with need=1 is illegal input; rgb is then 0.
- Memory contract: mem_addr and mem_req are stable until acked. mem_ack while mem_req=0 is ignored.

Test Plan:
- Reset mid-fetch: drop reset_ while mem_req=1 -> mem_req, rgb and underrun are 0 in the same cycle. After release, the fetch restarts at addr 0.
- Single-cycle-ack memory, mem[a] holding pixels 4a..4a+3 (value = pixel index mod 256), full 800x600 timing -> rgb equals (vNeed*800+hNeed) mod 256 one clk after need; rgb=0 when need=0; underrun stays 0.
- Address sequence after line_start at vNeed=5 -> addresses 1200..1399 are issued in order; after 200 acks mem_req=0.
- Wrap: line_start at vNeed=599 -> fetch_line=0, first mem_addr=BASE_ADDR; next frame line 0 displays the line-0 pattern.
- Slow memory, ack every 8th cycle (200 words need 1600 clk, more than the 1056-clk line) -> underrun sets at the next line_start; mem_req low for 1 cycle, then restarts at word 0 of the new line.
- Stall then resume: hold mem_ack=0 for 300 cycles mid-line -> mem_addr stays constant; the fetch completes before the next line_start; no underrun.
